// File: rtl/sram_access_controller.sv
// Sequences 32-bit loads/stores onto a 16-bit SRAM as two fixed-length half-word phases.
// Optional SRAM_RANGE_CHECK_EN: out-of-window accesses skip the SRAM and complete in one cycle.
module sram_access_controller #(
  parameter int ADDRESS_LEN  = 32,
  parameter int SRAM_ADDR_W  = 18,
  parameter int PHASE_CYCLES = 2,
  parameter int DATA_BASE    = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [ADDRESS_LEN-1:0] address,
  input  logic [ADDRESS_LEN-1:0] write_data,
  output logic [ADDRESS_LEN-1:0] read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_we_n,
  output logic                   sram_oe_n,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(PHASE_CYCLES - 1);

  state_t                   r_state;
  logic [3:0]               r_cnt;
  logic                     r_is_wr;
  logic [SRAM_ADDR_W-2:0]   r_word;
  logic [31:0]              r_wdata;
  logic [15:0]              r_rd_lo;
  logic [ADDRESS_LEN-1:0]   r_read_data;
  logic [SRAM_ADDR_W-1:0]   r_sram_addr;
  logic [15:0]              r_sram_dq_out;
  logic                     r_sram_dq_oe;
  logic                     r_sram_we_n;
  logic                     r_sram_oe_n;

  state_t                   w_state_nxt;
  logic [3:0]               w_cnt_nxt;
  logic                     w_is_wr_nxt;
  logic [SRAM_ADDR_W-2:0]   w_word_nxt;
  logic [31:0]              w_wdata_nxt;
  logic                     w_req;
  logic                     w_last;
  logic                     w_oor;
  logic                     w_phase_nxt;
  logic                     w_ready;
  logic [ADDRESS_LEN-1:0]   w_off_full;
  logic                     w_unused;

  assign w_req      = rd_en | wr_en;
  assign w_last     = (r_cnt == LAST_CNT);
  assign w_off_full = address - ADDRESS_LEN'(DATA_BASE);
  // Byte offset bits and (without range checking) the bits above the window are dropped.
  assign w_unused   = ^{w_off_full[ADDRESS_LEN-1:SRAM_ADDR_W+1], w_off_full[1:0]};

`ifdef SRAM_RANGE_CHECK_EN
  assign w_oor = |w_off_full[ADDRESS_LEN-1:SRAM_ADDR_W+1];
`else
  assign w_oor = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_is_wr_nxt = r_is_wr;
    w_word_nxt  = r_word;
    w_wdata_nxt = r_wdata;
    w_ready     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = ~w_req;
        if (w_req) begin
          w_is_wr_nxt = wr_en;
          w_word_nxt  = w_off_full[SRAM_ADDR_W:2];
          w_wdata_nxt = write_data[31:0];
          w_cnt_nxt   = 4'd0;
          w_state_nxt = w_oor ? S_DONE : S_LOW;
        end
      end
      S_LOW: begin
        if (w_last) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = S_HIGH;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_HIGH: begin
        if (w_last) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_DONE: begin
        w_ready     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_phase_nxt = (w_state_nxt == S_LOW) || (w_state_nxt == S_HIGH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_is_wr <= 1'b0;
      r_word  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_is_wr <= w_is_wr_nxt;
      r_word  <= w_word_nxt;
      r_wdata <= w_wdata_nxt;
    end
  end

  // SRAM pins are registered from the next-state view so each phase starts on its first cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sram_addr   <= '0;
      r_sram_dq_out <= '0;
      r_sram_dq_oe  <= 1'b0;
      r_sram_we_n   <= 1'b1;
      r_sram_oe_n   <= 1'b1;
    end else begin
      if (w_state_nxt == S_LOW) begin
        r_sram_addr   <= {w_word_nxt, 1'b0};
        r_sram_dq_out <= w_wdata_nxt[15:0];
      end else if (w_state_nxt == S_HIGH) begin
        r_sram_addr   <= {w_word_nxt, 1'b1};
        r_sram_dq_out <= w_wdata_nxt[31:16];
      end
      r_sram_dq_oe <= w_phase_nxt & w_is_wr_nxt;
      r_sram_we_n  <= ~(w_phase_nxt & w_is_wr_nxt & (w_cnt_nxt != LAST_CNT));
      r_sram_oe_n  <= ~(w_phase_nxt & ~w_is_wr_nxt);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_lo     <= '0;
      r_read_data <= '0;
    end else begin
      if ((r_state == S_LOW) && w_last && !r_is_wr) begin
        r_rd_lo <= sram_dq_in;
      end
      if ((r_state == S_HIGH) && w_last && !r_is_wr) begin
        r_read_data <= ADDRESS_LEN'({sram_dq_in, r_rd_lo});
      end
      if ((r_state == S_IDLE) && w_req && w_oor && !wr_en) begin
        r_read_data <= '0;
      end
    end
  end

  assign read_data   = r_read_data;
  assign ready       = w_ready;
  assign sram_addr   = r_sram_addr;
  assign sram_dq_out = r_sram_dq_out;
  assign sram_dq_oe  = r_sram_dq_oe;
  assign sram_we_n   = r_sram_we_n;
  assign sram_oe_n   = r_sram_oe_n;
  assign dbg_state   = r_state;

endmodule
